// File: rtl/tick_bcd_counter_pkg.sv
// Shared definitions for the tick-driven two-digit BCD counter.
package tick_bcd_counter_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned BCD_MAX       = 9;
    localparam int unsigned DEFAULT_LIMIT = 99;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = digit_t'(BCD_MAX);
    localparam digit_t DIGIT_ONE = digit_t'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage

// File: rtl/tick_bcd_counter_bcd.sv
// One BCD digit: loadable, up/down, wraps 9<->0 on its own.
module bcd_digit
    import tick_bcd_counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               down,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    // carry flags the roll-over value for the current direction; the top gates it with enable
    assign carry = down ? (value == '0) : (value == DIGIT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (enable) begin
            if (down) begin
                value <= (value == '0) ? DIGIT_MAX : value - DIGIT_ONE;
            end else begin
                value <= (value == DIGIT_MAX) ? '0 : value + DIGIT_ONE;
            end
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD counter advanced by upstream ticks, with IDLE/RUN/PAUSE control.
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pulse,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               down,
    output logic [DIGIT_W-1:0] units,
    output logic [DIGIT_W-1:0] tens,
    output logic               wrap,
    output logic               running
);

    localparam digit_t LIMIT_TENS  = digit_t'(LIMIT / 10);
    localparam digit_t LIMIT_UNITS = digit_t'(LIMIT % 10);

    state_t state, next_state;

    logic   step, at_limit, at_zero, wrap_step, load;
    logic   units_enable, tens_enable, units_carry, tens_carry;
    digit_t units_load, tens_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) next_state = RUN;
                RUN:     if (stop)  next_state = PAUSE;
                PAUSE:   if (start) next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);

    // Terminal detection lives here; digits only wrap 9<->0 locally
    assign step      = (state == RUN) && pulse && !clear;
    assign at_limit  = (tens == LIMIT_TENS) && (units == LIMIT_UNITS);
    assign at_zero   = down && units_carry && tens_carry;
    assign wrap_step = step && (down ? at_zero : at_limit);
    assign load      = clear || wrap_step;

    assign units_load   = (wrap_step && down) ? LIMIT_UNITS : '0;
    assign tens_load    = (wrap_step && down) ? LIMIT_TENS  : '0;
    assign units_enable = step && !wrap_step;
    assign tens_enable  = units_enable && units_carry;

    bcd_digit u_units (
        .clk        (clk),
        .reset      (reset),
        .enable     (units_enable),
        .down       (down),
        .load       (load),
        .load_value (units_load),
        .value      (units),
        .carry      (units_carry)
    );

    bcd_digit u_tens (
        .clk        (clk),
        .reset      (reset),
        .enable     (tens_enable),
        .down       (down),
        .load       (load),
        .load_value (tens_load),
        .value      (tens),
        .carry      (tens_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_step;
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench: two counters (LIMIT 99 and 15) share stimulus against an integer model.
module tb_tick_bcd_counter;

    logic clk = 1'b0;
    logic reset, pulse, start, stop, clear, down;
    logic [3:0] units_a, tens_a, units_b, tens_b;
    logic       wrap_a, running_a, wrap_b, running_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] units;
        logic       wrap;
        logic       running;
    } exp_t;

    exp_t sb[$];

    int m_cnt[2];
    int m_state[2];
    bit m_wrap[2];
    int m_limit[2] = '{99, 15};

    always #5 clk = ~clk;

    tick_bcd_counter #(.LIMIT(99)) dut_a (
        .clk(clk), .reset(reset), .pulse(pulse), .start(start), .stop(stop),
        .clear(clear), .down(down), .units(units_a), .tens(tens_a),
        .wrap(wrap_a), .running(running_a)
    );

    tick_bcd_counter #(.LIMIT(15)) dut_b (
        .clk(clk), .reset(reset), .pulse(pulse), .start(start), .stop(stop),
        .clear(clear), .down(down), .units(units_b), .tens(tens_b),
        .wrap(wrap_b), .running(running_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_state[d] = 0; m_wrap[d] = 1'b0;
        end
    endtask

    task automatic model_clock(input bit p, input bit st, input bit sp, input bit cl, input bit dn);
        for (int d = 0; d < 2; d++) begin
            m_wrap[d] = 1'b0;
            if (cl) begin
                m_cnt[d] = 0; m_state[d] = 0;
            end else begin
                if (m_state[d] == 1 && p) begin
                    if (dn) begin
                        if (m_cnt[d] == 0) begin m_cnt[d] = m_limit[d]; m_wrap[d] = 1'b1; end
                        else m_cnt[d] = m_cnt[d] - 1;
                    end else begin
                        if (m_cnt[d] == m_limit[d]) begin m_cnt[d] = 0; m_wrap[d] = 1'b1; end
                        else m_cnt[d] = m_cnt[d] + 1;
                    end
                end
                if (m_state[d] == 0 && st) m_state[d] = 1;
                else if (m_state[d] == 1 && sp) m_state[d] = 2;
                else if (m_state[d] == 2 && st) m_state[d] = 1;
            end
        end
    endtask

    task automatic push_expected();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.tens    = 4'(m_cnt[d] / 10);
            e.units   = 4'(m_cnt[d] % 10);
            e.wrap    = m_wrap[d];
            e.running = (m_state[d] == 1);
            sb.push_back(e);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        e = sb.pop_front();
        check("a_tens", {4'd0, tens_a}, {4'd0, e.tens});
        check("a_units", {4'd0, units_a}, {4'd0, e.units});
        check("a_wrap", {7'd0, wrap_a}, {7'd0, e.wrap});
        check("a_running", {7'd0, running_a}, {7'd0, e.running});
        e = sb.pop_front();
        check("b_tens", {4'd0, tens_b}, {4'd0, e.tens});
        check("b_units", {4'd0, units_b}, {4'd0, e.units});
        check("b_wrap", {7'd0, wrap_b}, {7'd0, e.wrap});
        check("b_running", {7'd0, running_b}, {7'd0, e.running});
    endtask

    // One clock: drive inputs, predict, then compare #1 after the edge
    task automatic cycle(input bit p, input bit st, input bit sp, input bit cl, input bit dn);
        pulse = p; start = st; stop = sp; clear = cl; down = dn;
        model_clock(p, st, sp, cl, dn);
        push_expected();
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic pulses(input int n, input bit dn);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, dn);
    endtask

    task automatic restart();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit wrap_seen;
        reset = 1'b1; pulse = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; down = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_count", {tens_a, units_a}, 8'h00);
        check("reset_a_flags", {6'd0, wrap_a, running_a}, 8'd0);
        reset = 1'b0;

        // start with a pulse in IDLE: no step
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_pulse_nostep", {tens_a, units_a}, 8'h00);

        // 1-in-4 tick stream, 12 pulses
        wrap_seen = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cycle(i % 4 == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            wrap_seen |= wrap_a;
        end
        check("up12_count", {tens_a, units_a}, 8'h12);
        check("up12_running", {7'd0, running_a}, 8'd1);
        check("up12_no_wrap", {7'd0, wrap_seen}, 8'd0);

        // up to 99 then wrap
        pulses(87, 1'b0);
        check("at_99", {tens_a, units_a}, 8'h99);
        pulses(1, 1'b0);
        check("wrap99_count", {tens_a, units_a}, 8'h00);
        check("wrap99_flag", {7'd0, wrap_a}, 8'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap99_one_cycle", {7'd0, wrap_a}, 8'd0);

        // LIMIT=15: 16th pulse wraps
        restart();
        pulses(15, 1'b0);
        check("b_at_15", {tens_b, units_b}, 8'h15);
        pulses(1, 1'b0);
        check("b_wrap16_count", {tens_b, units_b}, 8'h00);
        check("b_wrap16_flag", {7'd0, wrap_b}, 8'd1);

        // down wrap, direction flip gives back-to-back wraps, borrow
        restart();
        pulses(1, 1'b1);
        check("down_wrap_count", {tens_a, units_a}, 8'h99);
        check("down_wrap_flag", {7'd0, wrap_a}, 8'd1);
        check("b_down_wrap_count", {tens_b, units_b}, 8'h15);
        pulses(1, 1'b0);
        check("b2b_wrap_up", {wrap_a, 3'd0, units_a}, 8'h80);
        pulses(1, 1'b1);
        check("b2b_wrap_down", {wrap_a, 3'd0, units_a}, 8'h89);
        pulses(1, 1'b1);
        check("down_98", {tens_a, units_a}, 8'h98);
        pulses(88, 1'b1);
        check("down_10", {tens_a, units_a}, 8'h10);
        pulses(1, 1'b1);
        check("borrow_09", {tens_a, units_a}, 8'h09);

        // pause / resume
        restart();
        pulses(5, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stop_step_06", {tens_a, units_a}, 8'h06);
        check("paused", {7'd0, running_a}, 8'd0);
        pulses(3, 1'b0);
        check("paused_hold_06", {tens_a, units_a}, 8'h06);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1, 1'b0);
        check("resume_07", {tens_a, units_a}, 8'h07);

        // clear beats stop and pulse; start in RUN is inert
        restart();
        pulses(42, 1'b0);
        check("at_42", {tens_a, units_a}, 8'h42);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_prio_count", {tens_a, units_a}, 8'h00);
        check("clear_prio_flags", {6'd0, wrap_a, running_a}, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_in_run", {7'd0, running_a}, 8'd1);

        // async reset between edges
        restart();
        pulses(37, 1'b0);
        check("at_37", {tens_a, units_a}, 8'h37);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_count", {tens_a, units_a}, 8'h00);
        check("async_reset_flags", {6'd0, wrap_a, running_a}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pulses(4, 1'b0);
        check("post_reset_idle", {tens_a, units_a}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter LIMIT, default 99, the terminal count; legal range 1..99, held as two BCD digits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port pulse, input, 1 bit: one-cycle tick from the upstream pulse generator, sampled synchronously.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin or resume counting.
REQ-006 The block SHALL have port stop, input, 1 bit: request to pause counting.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous return to zero and idle.
REQ-008 The block SHALL have port down, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-009 The block SHALL have port units, output, 4 bits: BCD units digit, registered.
REQ-010 The block SHALL have port tens, output, 4 bits: BCD tens digit, registered.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle flag, set on terminal wrap.
REQ-012 The block SHALL have port running, output, 1 bit: high exactly while the FSM is in RUN.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and PAUSE. Count is held in IDLE and PAUSE.
REQ-014 Transitions SHALL be: IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; any state -clear-> IDLE.
REQ-015 Control priority SHALL be clear > stop > start. start in RUN SHALL have no effect; stop in IDLE or PAUSE SHALL have no effect.
REQ-016 A count step SHALL occur only on an edge where the current state is RUN and pulse = 1. Latency: units, tens and wrap update on that same edge.
REQ-017 Up step: if count == LIMIT, count SHALL become 00 with wrap = 1. Else units SHALL increment; units 9 -> 0 SHALL carry into tens.
REQ-018 Down step: if count == 00, count SHALL become LIMIT with wrap = 1. Else units SHALL decrement; units 0 -> 9 SHALL borrow from tens.
REQ-019 wrap SHALL be 1 for exactly one cycle after a wrapping step and 0 otherwise. Back-to-back wrapping steps SHALL give back-to-back wrap pulses.
REQ-020 Digits SHALL never leave 0..9, and count SHALL never exceed LIMIT.
REQ-021 stop with pulse in RUN: the step SHALL be taken, then the next state is PAUSE.
REQ-022 start with pulse in IDLE or PAUSE: no step; the first counted pulse is the next one.
REQ-023 clear with pulse: count SHALL be 00, wrap SHALL be 0, next state IDLE, no step.
REQ-024 A change of down takes effect on the next step; no step SHALL occur without pulse.
REQ-025 running SHALL be derived from the registered state, with no combinational path from inputs.

Reset
REQ-026 reset high SHALL immediately force state = IDLE, units = 0, tens = 0, wrap = 0 and running = 0, regardless of clk.
REQ-027 Reset asserted mid-count SHALL discard the count. After deassertion the block SHALL wait in IDLE for start; pulses arriving meanwhile SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold: the state encoding (IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10), BCD digit width 4, and the constants BCD_MAX = 9 and DEFAULT_LIMIT = 99.
REQ-029 A sub-module bcd_digit SHALL be instantiated twice. It has enable, direction and load/clear inputs, carry/borrow out, and terminal-value compare handled at top level.

Verification
REQ-030 Scenario, up count: upstream pulse generator ticking 1-in-4 cycles, reset then start, 12 pulses -> tens = 1, units = 2, running = 1, wrap never asserted.
REQ-031 Scenario, wrap at LIMIT = 99: count to 99, one more pulse -> 00 with wrap = 1 for exactly one cycle. With LIMIT = 15, the 16th pulse -> 00 with wrap = 1.
REQ-032 Scenario, down wrap: from 00 with down = 1, one pulse -> tens = 9, units = 9 (LIMIT = 99) with wrap = 1. Then a pulse -> 98; from 10 a pulse -> 09.
REQ-033 Scenario, pause/resume: stop asserted with a pulse at count 05 -> 06 then PAUSE. 3 pulses -> still 06. start then a pulse -> 07.
REQ-034 Scenario, clear and stop priority: clear, stop and pulse together in RUN at 42 -> 00, IDLE, wrap = 0. start in RUN -> no change.
REQ-035 Scenario, async reset: reset raised between clk edges at 37 -> outputs 0 before the next edge. Pulses after release without start -> count stays 00.
